i2c_codec_target: RTL

- I2C write-only target (responder) modelling the codec's control port: the far end of our 20 kHz codec configuration master.
- Receives 3-byte write frames {device address+W, reg[6:0]+data[8], data[7:0]} and stores each 9-bit value in an internal register file.
- Exposes the register file to the host side.
- Used in simulation as the codec model and in FPGA-to-FPGA loopback tests of the configuration path.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_line_filter.sv | 77 +++++++
 rtl/i2c_codec_target.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C codec control-port target: default codec
// address, register-file size, reset register address, input filter length
// and the target FSM state encoding.
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0] CODEC_DEV_ADDR  = 7'h1A;
    localparam logic [6:0] CODEC_RST_REG   = 7'h0F;
    localparam int         CODEC_NUM_REGS  = 10;
    localparam int         CODEC_FILT_LEN  = 4;
    localparam int         CODEC_REG_W     = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE_HI,
        ST_ACK_HI,
        ST_BYTE_LO,
        ST_ACK_LO,
        ST_DONE,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Conditions one I2C bus line: 2-FF synchronizer followed by a stability
// filter. The filtered level only follows the synchronized input after it has
// differed from the current level for FILT_LEN consecutive iCLK samples.
// Edge pulses are registered so they coincide with the new filtered level.
//
// Ports:
//   iCLK    - system clock
//   iRST    - synchronous active-high reset (presets the line to idle-high)
//   iLINE   - raw bus line
//   oLEVEL  - filtered level
//   oRISE   - one-cycle pulse when the filtered level goes 0->1
//   oFALL   - one-cycle pulse when the filtered level goes 1->0
// -----------------------------------------------------------------------------
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iLINE,
    output logic oLEVEL,
    output logic oRISE,
    output logic oFALL
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync1_d = iLINE;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any sample equal to the current level restarts the stability count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign oLEVEL = level_q;
    assign oRISE  = rise_q;
    assign oFALL  = fall_q;

endmodule

// File: rtl/i2c_codec_target.sv
// -----------------------------------------------------------------------------
// i2c_codec_target
// Write-only I2C target modelling a codec control port. Accepts 3-byte frames
// {DEV_ADDR+W, reg[6:0]+data[8], data[7:0]} and stores the 9-bit value in an
// internal register file. Writing RST_REG clears the whole register file.
//
// Ports:
//   iCLK       - system clock, at least 20x SCL
//   iRST       - synchronous active-high reset
//   iI2C_SCLK  - SCL from bus
//   iI2C_SDAT  - SDA sampled from bus
//   oSDAT_OE   - 1 = pull SDA low (open-drain ACK)
//   iRD_ADDR   - host read address
//   oRD_DATA   - combinational register read, 0 for unimplemented addresses
//   oWR_STB    - one-cycle pulse on each committed write
//   oWR_ADDR   - register address of the last commit
//   oWR_DATA   - data of the last commit
//   oERR       - one-cycle pulse when a frame targets an unknown register
// -----------------------------------------------------------------------------
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR,
    parameter int         NUM_REGS = CODEC_NUM_REGS,
    parameter logic [6:0] RST_REG  = CODEC_RST_REG,
    parameter int         FILT_LEN = CODEC_FILT_LEN
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iI2C_SCLK,
    input  logic       iI2C_SDAT,
    output logic       oSDAT_OE,
    input  logic [3:0] iRD_ADDR,
    output logic [8:0] oRD_DATA,
    output logic       oWR_STB,
    output logic [6:0] oWR_ADDR,
    output logic [8:0] oWR_DATA,
    output logic       oERR
);

    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iLINE  (iI2C_SCLK),
        .oLEVEL (scl_lvl),
        .oRISE  (scl_rise),
        .oFALL  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iLINE  (iI2C_SDAT),
        .oLEVEL (sda_lvl),
        .oRISE  (sda_rise),
        .oFALL  (sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic       d8_q, d8_d;
    logic       oe_q, oe_d;
    logic       wr_stb_q, wr_stb_d;
    logic       err_q, err_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] regs_d [NUM_REGS];

    logic       start_cond, stop_cond;
    logic [7:0] byte_nxt;
    logic [8:0] wr_val;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign byte_nxt   = {shift_q[6:0], sda_lvl};
    // Low data byte stays in the shift register through ACK_LO (no sampling there).
    assign wr_val     = {d8_q, shift_q};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        d8_d       = d8_q;
        oe_d       = oe_q;
        wr_stb_d   = 1'b0;
        err_d      = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        // Bus conditions override everything, including a byte completing now.
        if (start_cond) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (stop_cond) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
                    if (scl_rise) begin
                        shift_d   = byte_nxt;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                state_d = (byte_nxt == {DEV_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                            end else if (state_q == ST_BYTE_HI) begin
                                reg_addr_d = byte_nxt[7:1];
                                d8_d       = byte_nxt[0];
                                state_d    = ST_ACK_HI;
                            end else begin
                                state_d = ST_ACK_LO;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_ACK_HI, ST_ACK_LO: begin
                    // First SCL fall after bit 8 starts driving ACK, the next one ends it.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_BYTE_HI;
                            end else if (state_q == ST_ACK_HI) begin
                                state_d = ST_BYTE_LO;
                            end else begin
                                state_d = ST_DONE;
                                if (reg_addr_q < NUM_REGS_A) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (reg_addr_q == 7'(i)) regs_d[i] = wr_val;
                                    end
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = reg_addr_q;
                                    wr_data_d = wr_val;
                                end else if (reg_addr_q == RST_REG) begin
                                    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = reg_addr_q;
                                    wr_data_d = wr_val;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            d8_q       <= 1'b0;
            oe_q       <= 1'b0;
            wr_stb_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            d8_q       <= d8_d;
            oe_q       <= oe_d;
            wr_stb_q   <= wr_stb_d;
            err_q      <= err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        oRD_DATA = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iRD_ADDR == 4'(i)) oRD_DATA = regs_q[i];
        end
    end

    assign oSDAT_OE = oe_q;
    assign oWR_STB  = wr_stb_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oERR     = err_q;

endmodule
